// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch condition resolve, 2-bit BHT predictor and perf counters
module branch_resolve_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pred_valid,
   input  logic [XLEN-1:0]  pred_pc,
   output logic             pred_taken,
   output logic             pred_ack,
   input  logic             res_valid,
   input  logic [XLEN-1:0]  res_pc,
   input  logic [XLEN-1:0]  res_rs1,
   input  logic [XLEN-1:0]  res_rs2,
   input  logic [2:0]       res_funct3,
   input  logic             res_pred_taken,
   output logic             br_taken,
   output logic             br_done,
   output logic             mispredict,
   output logic             illegal_br,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [IDX_W-1:0] res_idx, pred_idx;
   logic             eq, lt, ltu, cond, legal, upd_en, misp;
   logic [1:0]       res_ctr, upd_ctr, pred_ctr;

   logic             pred_taken_q, pred_taken_d, pred_ack_q;
   logic             br_taken_q, br_taken_d, br_done_q, mispredict_q, illegal_q;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;

   // Word-aligned PC bits select the counter; the rest simply alias.
   assign res_idx  = res_pc[IDX_W+1:2];
   assign pred_idx = pred_pc[IDX_W+1:2];
   logic unused_pc_bits;
   assign unused_pc_bits = &{1'b0, res_pc[XLEN-1:IDX_W+2], res_pc[1:0],
                             pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

   assign eq  = (res_rs1 == res_rs2);
   assign lt  = ($signed(res_rs1) < $signed(res_rs2));
   assign ltu = (res_rs1 < res_rs2);

   always_comb begin
      cond = 1'b0;
      case (res_funct3)
         3'b000:  cond = eq;
         3'b001:  cond = !eq;
         3'b100:  cond = lt;
         3'b101:  cond = !lt;
         3'b110:  cond = ltu;
         3'b111:  cond = !ltu;
         default: cond = 1'b0;
      endcase
   end

   assign legal   = (res_funct3[2:1] != 2'b01);
   assign upd_en  = res_valid && legal;
   assign misp    = upd_en && (cond != res_pred_taken);
   assign res_ctr = bht_q[res_idx];

   always_comb begin
      upd_ctr = res_ctr;
      if (cond) begin
         if (res_ctr != 2'b11) upd_ctr = res_ctr + 2'd1;
      end else begin
         if (res_ctr != 2'b00) upd_ctr = res_ctr - 2'd1;
      end
   end

   // Write-first: a same-cycle update to the predicted entry is visible to fetch.
   assign pred_ctr = (upd_en && (res_idx == pred_idx)) ? upd_ctr : bht_q[pred_idx];

   always_comb begin
      pred_taken_d     = pred_valid && pred_ctr[1];
      br_taken_d       = res_valid ? cond : br_taken_q;
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (upd_en && (branch_cnt_q != {CNT_W{1'b1}}))
         branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (misp && (mispredict_cnt_q != {CNT_W{1'b1}}))
         mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else if (upd_en) begin
         bht_q[res_idx] <= upd_ctr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_taken_q     <= 1'b0;
         pred_ack_q       <= 1'b0;
         br_taken_q       <= 1'b0;
         br_done_q        <= 1'b0;
         mispredict_q     <= 1'b0;
         illegal_q        <= 1'b0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         pred_taken_q     <= pred_taken_d;
         pred_ack_q       <= pred_valid;
         br_taken_q       <= br_taken_d;
         br_done_q        <= res_valid;
         mispredict_q     <= misp;
         illegal_q        <= res_valid && !legal;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign pred_taken     = pred_taken_q;
   assign pred_ack       = pred_ack_q;
   assign br_taken       = br_taken_q;
   assign br_done        = br_done_q;
   assign mispredict     = mispredict_q;
   assign illegal_br     = illegal_q;
   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;
endmodule
